// File: rtl/mem_pkg.sv
// Purpose: shared types and default widths for the mem_writer frame-fill block.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_pkg;

  // Default geometry: 16 words of 8 bits.
  localparam int MEM_ADDR_W = 4;
  localparam int MEM_DATA_W = 8;

  // Writer FSM encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_e;

endpackage

// File: rtl/mem_writer_dist_ram.sv
// Purpose: distributed RAM, one synchronous write port and one asynchronous read port.
// Latency: write on the rising edge of clk; read is combinational (a -> spo).
// Backpressure: none; a write is taken on every cycle where we is high.
//
// Ports:
//   clk     - write clock
//   we      - write enable
//   wa, wd  - write address / write data
//   a, spo  - asynchronous read address / read data
module dist_ram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] a,
  output logic [DATA_W-1:0] spo
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Contents are intentionally never reset.
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wa] <= wd;
    end
  end

  assign spo = mem_q[a];

endmodule

// File: rtl/mem_writer.sv
// Purpose: fills a DEPTH-word memory from a valid/ready pixel stream, then holds it for async readout.
// Latency: one write per cycle; a write is visible on spo the cycle after its edge; done rises the cycle after the last write.
// Backpressure: in_ready is registered from FSM state only (high in FILL), never depends on in_valid.
//
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   start            - one-cycle pulse, (re)arms a fill from address 0
//   in_valid/in_data - pixel stream input; in_ready - accepting this cycle
//   a, spo           - asynchronous read port into the stored frame
//   wr_addr          - next address to be written
//   done             - memory holds a complete fill
//   cksum            - XOR of words written since last start/reset
//                      (present only when MEM_WRITER_CKSUM_EN is defined)
module mem_writer
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] a,
  output logic [DATA_W-1:0] spo,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              done
`ifdef MEM_WRITER_CKSUM_EN
  ,
  output logic [DATA_W-1:0] cksum
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q;
  logic              in_ready_q;
  logic              done_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [ADDR_W-1:0] wr_addr_d;
  logic              xfer;

  // start and rst both pre-empt a transfer offered on the same edge.
  assign xfer      = in_ready_q & in_valid & ~start & ~rst;
  assign wr_addr_d = wr_addr_q + ADDR_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_addr_q  <= '0;
      in_ready_q <= 1'b0;
      done_q     <= 1'b0;
    end else if (start) begin
      state_q    <= FILL;
      wr_addr_q  <= '0;
      in_ready_q <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (xfer) begin
            // Natural wrap of the address brings it back to 0 on the last word.
            wr_addr_q <= wr_addr_d;
            if (wr_addr_q == LAST_ADDR) begin
              state_q    <= FULL;
              in_ready_q <= 1'b0;
              done_q     <= 1'b1;
            end
          end
        end
        default: begin
          // IDLE and FULL hold until start.
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign done     = done_q;
  assign wr_addr  = wr_addr_q;

  dist_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk (clk),
    .we  (xfer),
    .wa  (wr_addr_q),
    .wd  (in_data),
    .a   (a),
    .spo (spo)
  );

`ifdef MEM_WRITER_CKSUM_EN
  logic [DATA_W-1:0] cksum_q;

  always_ff @(posedge clk) begin
    if (rst || start) begin
      cksum_q <= '0;
    end else if (xfer) begin
      cksum_q <= cksum_q ^ in_data;
    end
  end

  assign cksum = cksum_q;
`endif

endmodule

// File: tb/tb_mem_writer.sv
// Purpose: self-checking bench for mem_writer using a write scoreboard and a behavioural model.
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: model predicts in_ready from its own FSM state.
module tb_mem_writer;

  logic       clk = 1'b0;
  logic       rst, start, in_valid, in_ready, done;
  logic [7:0] in_data, spo;
  logic [3:0] a, wr_addr;
`ifdef MEM_WRITER_CKSUM_EN
  logic [7:0] cksum;
`endif

  always #5 clk = ~clk;

  mem_writer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .a        (a),
    .spo      (spo),
    .wr_addr  (wr_addr),
    .done     (done)
`ifdef MEM_WRITER_CKSUM_EN
    ,
    .cksum    (cksum)
`endif
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Scoreboard of accepted writes: {addr, data}.
  logic [11:0] sb_q[$];

  // Behavioural model: 0=IDLE 1=FILL 2=FULL.
  int         m_state = 0;
  logic [3:0] m_addr  = '0;
  logic [7:0] m_ck    = '0;
  logic [7:0] m_mem   [16];
  logic       m_known [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus, advance the model, then check outputs and drain the scoreboard.
  task automatic cyc(input logic r, input logic s, input logic v, input logic [7:0] d);
    logic [11:0] w;
    rst      = r;
    start    = s;
    in_valid = v;
    in_data  = d;
    if (r) begin
      m_state = 0;
      m_addr  = 4'd0;
      m_ck    = 8'd0;
    end else if (s) begin
      m_state = 1;
      m_addr  = 4'd0;
      m_ck    = 8'd0;
    end else if (m_state == 1 && v) begin
      sb_q.push_back({m_addr, d});
      m_mem[m_addr]   = d;
      m_known[m_addr] = 1'b1;
      m_ck            = m_ck ^ d;
      if (m_addr == 4'd15) m_state = 2;
      m_addr = m_addr + 4'd1;
    end
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    check("in_ready", 32'(in_ready), 32'(m_state == 1));
    check("done", 32'(done), 32'(m_state == 2));
    check("wr_addr", 32'(wr_addr), 32'(m_addr));
`ifdef MEM_WRITER_CKSUM_EN
    check("cksum", 32'(cksum), 32'(m_ck));
`endif
    while (sb_q.size() > 0) begin
      w = sb_q.pop_front();
      a = w[11:8];
      #1;
      check($sformatf("spo_wr@%0d", w[11:8]), 32'(spo), 32'(w[7:0]));
    end
  endtask

  task automatic sweep();
    for (int i = 0; i < 16; i++) begin
      if (m_known[i]) begin
        a = 4'(i);
        #1;
        check($sformatf("sweep@%0d", i), 32'(spo), 32'(m_mem[i]));
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    a        = 4'd0;
    for (int i = 0; i < 16; i++) m_known[i] = 1'b0;

    // Reset state.
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 8'h33);  // IDLE ignores in_valid

    // Continuous fill 0x00..0x0F.
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 1'b1, 8'(i));
    check("done_after_16", 32'(done), 32'd1);
    check("wr_addr_wrapped", 32'(wr_addr), 32'd0);
    for (int i = 0; i < 16; i++) begin
      a = 4'(i);
      #1;
      check($sformatf("ramp@%0d", i), 32'(spo), 32'(i));
    end

    // FULL ignores in_valid.
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 8'hFF);
    check("full_in_ready", 32'(in_ready), 32'd0);
    a = 4'd3;
    #1;
    check("full_spo3", 32'(spo), 32'h03);

    // Restart from FULL, single write.
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 8'hA5);
    check("restart_done", 32'(done), 32'd0);
    a = 4'd0;
    #1;
    check("restart_spo0", 32'(spo), 32'hA5);
    a = 4'd1;
    #1;
    check("restart_spo1", 32'(spo), 32'h01);

    // start in FILL with a simultaneous transfer: start wins.
    cyc(1'b0, 1'b0, 1'b1, 8'h5A);
    cyc(1'b0, 1'b1, 1'b1, 8'h77);
    check("start_wins_addr", 32'(wr_addr), 32'd0);
    a = 4'd2;
    #1;
    check("start_wins_spo2", 32'(spo), 32'h02);

    // Fill with in_valid toggling every other cycle.
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 8'hEE);
      cyc(1'b0, 1'b0, 1'b1, 8'(8'h40 + i));
    end
    check("toggle_done", 32'(done), 32'd1);
    sweep();

    // Reset after 7 transfers; memory retained, reset-edge write dropped.
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b1, 8'(8'h10 + i));
    cyc(1'b1, 1'b0, 1'b1, 8'h99);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    for (int i = 0; i < 7; i++) begin
      a = 4'(i);
      #1;
      check($sformatf("rst_keep@%0d", i), 32'(spo), 32'(8'h10 + i));
    end
    a = 4'd7;
    #1;
    check("rst_nowrite@7", 32'(spo), 32'h47);

`ifdef MEM_WRITER_CKSUM_EN
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 8'h01);
    cyc(1'b0, 1'b0, 1'b1, 8'h02);
    cyc(1'b0, 1'b0, 1'b1, 8'h04);
    check("cksum_3", 32'(cksum), 32'h07);
    cyc(1'b0, 1'b0, 1'b1, 8'h08);
    check("cksum_4", 32'(cksum), 32'h0F);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    check("cksum_start", 32'(cksum), 32'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_writer.md
MEM_WRITER -- requirements
Module: mem_writer

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, meaning memory address width; DEPTH = 2**ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 8, meaning pixel/word width.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse arming a fill from address 0.
REQ-006 SHALL have port in_valid  input  1  in_data holds a valid pixel.
REQ-007 SHALL have port in_data  input  DATA_W  pixel to store.
REQ-008 SHALL have port in_ready  output  1  writer accepts in_data this cycle.
REQ-009 SHALL have port a  input  ADDR_W  asynchronous read address.
REQ-010 SHALL have port spo  output  DATA_W  combinational read data at address a.
REQ-011 SHALL have port wr_addr  output  ADDR_W  next address to be written.
REQ-012 SHALL have port done  output  1  high while memory holds a complete fill.

Function
REQ-013 SHALL implement FSM states IDLE, FILL, FULL.
REQ-014 SHALL, in IDLE, drive in_ready=0, done=0; start moves to FILL with wr_addr=0.
REQ-015 SHALL, in FILL, drive in_ready=1; transfer occurs when in_valid&&in_ready at a rising edge.
REQ-016 SHALL, on transfer, write in_data to mem[wr_addr] at that edge and increment wr_addr modulo DEPTH.
REQ-017 SHALL, on transfer with wr_addr=DEPTH-1, enter FULL next cycle with wr_addr wrapped to 0.
REQ-018 SHALL, in FULL, drive in_ready=0, done=1; in_valid ignored, memory unchanged.
REQ-019 SHALL, on start in FULL, return to FILL with wr_addr=0 and done=0 next cycle; old contents remain until overwritten.
REQ-020 SHALL, on start in FILL, restart at wr_addr=0; a simultaneous transfer is dropped (start wins, no write).
REQ-021 SHALL make spo = mem[a] combinationally; a write is visible on spo from the cycle after its edge.
REQ-022 SHALL sustain one write per cycle with no bubbles; fill of DEPTH words completes DEPTH cycles after first transfer.
REQ-023 SHALL hold in_ready independent of in_valid (no combinational valid->ready path).

Reset
REQ-024 SHALL, on rst, set state=IDLE, wr_addr=0, done=0, in_ready=0 at the next edge.
REQ-025 SHALL give rst priority over start and in_valid; reset mid-FILL abandons the fill.
REQ-026 SHALL NOT clear memory contents on reset; spo after reset is unspecified until written.

Configuration
REQ-027 SHALL, with MEM_WRITER_CKSUM_EN defined, add output cksum (DATA_W): XOR of all words written since the last start/reset, cleared to 0 on reset and start, updated on each transfer.
REQ-028 SHALL, without MEM_WRITER_CKSUM_EN, omit the cksum port and its logic entirely.

Structure
REQ-029 SHALL place state encoding (IDLE=0, FILL=1, FULL=2) and ADDR_W/DATA_W defaults in shared package mem_pkg.
REQ-030 SHALL instantiate sub-module dist_ram (one sync write port, one async read port a/spo) for storage.

Verification
REQ-031 SHALL cover: rst, start, stream 0x00..0x0F with in_valid held -> done=1 after 16 transfers; sweeping a=0..15 gives spo=0x00..0x0F.
REQ-032 SHALL cover: in_valid toggled every other cycle during fill -> only valid cycles written, wr_addr advances only on transfers, done after 16th transfer.
REQ-033 SHALL cover: in FULL, in_valid=1 with in_data=0xFF for 5 cycles -> in_ready=0, spo at a=3 still 0x03.
REQ-034 SHALL cover: start after FULL, write 0xA5 once -> done=0, spo at a=0 is 0xA5, spo at a=1 still 0x01.
REQ-035 SHALL cover: rst asserted after 7 transfers -> next cycle IDLE, wr_addr=0, in_ready=0; mem[0..6] retained.
REQ-036 SHALL cover (MEM_WRITER_CKSUM_EN): write 0x01,0x02,0x04 then 0x08 -> cksum=0x07 after the third write, 0x0F after the fourth; start -> 0x00.
